// File: rtl/cordic_pkg.sv
// cordic_pkg
//   Shared constants and types for the CORDIC polar post-processing slice.
//   KINV      : 1/K CORDIC gain compensation factor, unsigned Q1.15.
//   PI_Q      : pi in Q4.11.
//   FRAC_DEF  : default number of fractional data bits.
//   POLAR_W   : data width of one field of the result word.
//   polar_t   : {mag, phase} result word stored in the output FIFO.
//   scale_pi  : rescales PI_Q to a different number of fractional bits.
package cordic_pkg;

  localparam int FRAC_DEF = 11;
  localparam int POLAR_W = 16;
  localparam int KINV_FRAC = 15;
  localparam logic [15:0] KINV = 16'd19898;
  localparam int PI_Q = 6434;

  typedef struct packed {
    logic [POLAR_W-1:0] mag;
    logic [POLAR_W-1:0] phase;
  } polar_t;

  // PI_Q is stored for FRAC_DEF fractional bits; other formats shift it.
  function automatic int scale_pi(input int frac);
    if (frac >= FRAC_DEF) begin
      return PI_Q << (frac - FRAC_DEF);
    end else begin
      return PI_Q >> (FRAC_DEF - frac);
    end
  endfunction

endpackage

// File: rtl/cordic_post_fifo.sv
// cordic_post_fifo
//   Show-ahead FIFO with occupancy count and drop-on-full behaviour.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous active-low reset (pointers, count, overflow)
//     wr_en    in   write request
//     wr_data  in   word to write
//     rd_en    in   consumer accepts the head (ignored while empty)
//     rd_data  out  head entry, zero while empty
//     count    out  number of stored entries, 0..DEPTH
//     overflow out  sticky; a write was dropped because the FIFO was full
module cordic_post_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // A write into a full FIFO still lands if the head leaves in the same cycle.
  always_comb begin
    empty = (count == '0);
    full = (count == (PTR_W + 1)'(DEPTH));
    pop = rd_en && !empty;
    push = wr_en && (!full || pop);
    drop = wr_en && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is never cleared; the count decides what is visible.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/cordic_polar_post.sv
// cordic_polar_post
//   Post-processing for a vectoring CORDIC: removes the CORDIC gain from the
//   magnitude, undoes the 180-degree pre-rotation on the angle, and buffers
//   the polar result in a show-ahead FIFO with valid/ready output.
//   Config macro: CORDIC_POST_ROUND_EN selects round-half-up on the magnitude
//   (default build truncates).
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous active-low reset
//     in_valid   in   CORDIC sample valid
//     x_in       in   CORDIC X output (magnitude x K), signed Q4.11
//     theta_in   in   CORDIC angle, signed Q4.11 radians
//     quad_in    in   original vector was pre-rotated by 180 degrees
//     mag_out    out  gain-compensated magnitude, Q4.11
//     phase_out  out  corrected angle in (-pi, pi], Q4.11
//     out_valid  out  FIFO head holds a result
//     out_ready  in   consumer accepts the head
//     overflow   out  sticky sample-drop flag
module cordic_polar_post
  import cordic_pkg::*;
#(
  parameter int WIDTH = POLAR_W,
  parameter int FRAC = FRAC_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] theta_in,
  input  logic             quad_in,
  output logic [WIDTH-1:0] mag_out,
  output logic [WIDTH-1:0] phase_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int PROD_W = WIDTH + 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] PI_W = WIDTH'(scale_pi(FRAC));

  logic [WIDTH-1:0] xc;
  logic [PROD_W-1:0] prod_c;
  logic s1_valid;
  logic [PROD_W-1:0] s1_prod;
  logic [WIDTH-1:0] s1_theta;
  logic s1_quad;
  logic [PROD_W:0] prod_rnd;
  logic [WIDTH-1:0] mag_c;
  logic [WIDTH-1:0] phase_c;
  logic theta_pos;
  logic s2_valid;
  polar_t s2_word;
  polar_t head;
  logic [CNT_W-1:0] fifo_count;

  // Negative X can only come from arithmetic noise near zero; clamp it away.
  always_comb begin
    xc = x_in[WIDTH-1] ? '0 : x_in;
    prod_c = PROD_W'(xc) * PROD_W'(KINV);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_prod <= prod_c;
      s1_theta <= theta_in;
      s1_quad <= quad_in;
    end
  end

  // One spare bit keeps the rounding add from wrapping.
  // KINV < 1, so the shifted product always fits in WIDTH-1 bits.
`ifdef CORDIC_POST_ROUND_EN
  localparam logic [PROD_W:0] RND = (PROD_W + 1)'(1) << (KINV_FRAC - 1);
  always_comb begin
    prod_rnd = {1'b0, s1_prod} + RND;
  end
`else
  always_comb begin
    prod_rnd = {1'b0, s1_prod};
  end
`endif

  // Pre-rotated vectors are moved back by pi toward the (-pi, pi] range;
  // theta == 0 maps to +pi so the result never lands on -pi.
  always_comb begin
    mag_c = WIDTH'(prod_rnd >> KINV_FRAC);
    theta_pos = !s1_theta[WIDTH-1] && (s1_theta != '0);
    if (!s1_quad) begin
      phase_c = s1_theta;
    end else if (theta_pos) begin
      phase_c = s1_theta - PI_W;
    end else begin
      phase_c = s1_theta + PI_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_word.mag <= mag_c;
      s2_word.phase <= phase_c;
    end
  end

  cordic_post_fifo #(
    .DATA_W($bits(polar_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s2_valid),
    .wr_data (s2_word),
    .rd_en   (out_ready),
    .rd_data (head),
    .count   (fifo_count),
    .overflow(overflow)
  );

  always_comb begin
    out_valid = (fifo_count != '0);
    mag_out = head.mag;
    phase_out = head.phase;
  end

endmodule

// File: tb/tb_cordic_polar_post.sv
// tb_cordic_polar_post
//   Self-checking bench for cordic_polar_post: directed table vectors,
//   hand-written backpressure/overflow/reset sequences and a randomized run,
//   all compared against a behavioural model (delay line + result queue).
module tb_cordic_polar_post;

  localparam int DEPTH = 4;
  localparam int KINV_I = 19898;
  localparam int PI_I = 6434;

  typedef struct {
    int mag;
    int phase;
  } res_t;

  typedef struct {
    int x;
    int theta;
    bit quad;
    int mag_t;
    int mag_r;
    int phase;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [15:0] x_in;
  logic [15:0] theta_in;
  logic quad_in;
  logic [15:0] mag_out;
  logic [15:0] phase_out;
  logic out_valid;
  logic out_ready;
  logic overflow;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: two-edge latency line and the buffered results.
  bit pipe_v [2];
  res_t pipe_d [2];
  res_t q [$];
  bit ovf;

  cordic_polar_post dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .x_in     (x_in),
    .theta_in (theta_in),
    .quad_in  (quad_in),
    .mag_out  (mag_out),
    .phase_out(phase_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Magnitude = max(x,0) / K, from plain integer arithmetic.
  function automatic int refMag(input int x);
    longint p;
    p = (x < 0) ? 0 : x;
    p = p * KINV_I;
`ifdef CORDIC_POST_ROUND_EN
    p = p + 16384;
`endif
    return int'(p / 32768);
  endfunction

  function automatic int refPhase(input int th, input bit quad);
    if (!quad) return th;
    if (th <= 0) return th + PI_I;
    return th - PI_I;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelEdge();
    bit full;
    bit pop;
    res_t r;
    if (!rst) begin
      pipe_v[0] = 1'b0;
      pipe_v[1] = 1'b0;
      q.delete();
      ovf = 1'b0;
      return;
    end
    full = (q.size() == DEPTH);
    pop = (q.size() != 0) && out_ready;
    if (pop) void'(q.pop_front());
    if (pipe_v[1]) begin
      if (!full || pop) q.push_back(pipe_d[1]);
      else ovf = 1'b1;
    end
    pipe_v[1] = pipe_v[0];
    pipe_d[1] = pipe_d[0];
    pipe_v[0] = in_valid;
    r.mag = refMag($signed(x_in));
    r.phase = refPhase($signed(theta_in), quad_in);
    pipe_d[0] = r;
  endtask

  task automatic checkModel();
    checkOutput("out_valid", int'(out_valid), int'(q.size() != 0));
    checkOutput("overflow", int'(overflow), int'(ovf));
    if (q.size() != 0) begin
      checkOutput("mag_out", int'($signed(mag_out)), q[0].mag);
      checkOutput("phase_out", int'($signed(phase_out)), q[0].phase);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(input bit v, input int x, input int th, input bit qd, input bit rdy);
    in_valid = v;
    x_in = 16'(x);
    theta_in = 16'(th);
    quad_in = qd;
    out_ready = rdy;
    tick();
  endtask

  task automatic randSample(input bit rdy, output int x, output int th, output bit qd);
    x = $signed(16'($urandom_range(0, 65535)));
    th = $signed(16'($urandom_range(0, 65535)));
    qd = 1'($urandom_range(0, 1));
    applyStimulus(1'b1, x, th, qd, rdy);
  endtask

  initial begin
    vec_t tbl [9];
    int xs;
    int ts;
    bit qs;
    int exp_m;

    tbl[0] = '{25684, 829, 1'b0, 15596, 15596, 829};
    tbl[1] = '{25684, 829, 1'b1, 15596, 15596, -5605};
    tbl[2] = '{25684, -829, 1'b1, 15596, 15596, 5605};
    tbl[3] = '{25684, 0, 1'b1, 15596, 15596, 6434};
    tbl[4] = '{3, 0, 1'b0, 1, 2, 0};
    tbl[5] = '{-100, 100, 1'b0, 0, 0, 100};
    tbl[6] = '{32767, -6434, 1'b1, 19897, 19897, 0};
    tbl[7] = '{16384, 6434, 1'b1, 9949, 9949, 0};
    tbl[8] = '{1, 3216, 1'b1, 0, 1, -3218};

    rst = 1'b0;
    in_valid = 1'b0;
    x_in = '0;
    theta_in = '0;
    quad_in = 1'b0;
    out_ready = 1'b0;
    pipe_v[0] = 1'b0;
    pipe_v[1] = 1'b0;
    ovf = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_mag", int'(mag_out), 0);
    checkOutput("rst_phase", int'(phase_out), 0);
    rst = 1'b1;

    // Directed vectors, one at a time, checking the two-edge latency.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, tbl[i].x, tbl[i].theta, tbl[i].quad, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      checkOutput("tbl_lat_early", int'(out_valid), 0);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      checkOutput("tbl_valid", int'(out_valid), 1);
`ifdef CORDIC_POST_ROUND_EN
      checkOutput("tbl_mag", int'($signed(mag_out)), tbl[i].mag_r);
`else
      checkOutput("tbl_mag", int'($signed(mag_out)), tbl[i].mag_t);
`endif
      checkOutput("tbl_phase", int'($signed(phase_out)), tbl[i].phase);
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("tbl_drained", int'(out_valid), 0);

    // Backpressure: six back-to-back samples into a stalled 4-entry FIFO.
    for (int i = 0; i < 6; i++) randSample(1'b0, xs, ts, qs);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    checkOutput("bp_overflow", int'(overflow), 1);
    checkOutput("bp_full_valid", int'(out_valid), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("bp_drain_empty", int'(out_valid), 0);
    checkOutput("bp_overflow_sticky", int'(overflow), 1);

    // Full FIFO: pop and write land on the same edge, the write is kept.
    for (int i = 0; i < 5; i++) randSample(1'b0, xs, ts, qs);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    exp_m = refMag(xs);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("full_pw_valid", int'(out_valid), 1);
    checkOutput("full_pw_mag", int'($signed(mag_out)), exp_m);
    checkOutput("full_pw_phase", int'($signed(phase_out)), refPhase(ts, qs));
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("full_pw_empty", int'(out_valid), 0);

    // Reset with three buffered and two in flight.
    for (int i = 0; i < 5; i++) randSample(1'b0, xs, ts, qs);
    checkOutput("mid_buffered", int'(out_valid), 1);
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    checkOutput("mid_rst_valid", int'(out_valid), 0);
    checkOutput("mid_rst_overflow", int'(overflow), 0);
    checkOutput("mid_rst_mag", int'(mag_out), 0);
    checkOutput("mid_rst_phase", int'(phase_out), 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
      checkOutput("mid_no_stale", int'(out_valid), 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      x_in = 16'($urandom_range(0, 65535));
      theta_in = 16'($urandom_range(0, 65535));
      quad_in = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_polar_post.md
# cordic_polar_post

Post-processing stage placed directly downstream of the 12-stage vectoring CORDIC. It takes the CORDIC's raw magnitude and angle outputs, removes the CORDIC gain (1/K), and restores the true angle for vectors that were pre-rotated by 180° before entering the CORDIC. It then buffers the polar result in a small FIFO with a valid/ready output handshake. The CORDIC pipeline cannot stall, so this block absorbs downstream backpressure and flags any sample it has to drop.

## Interface
- WIDTH, 16: sample width; magnitude and angle are signed Q4.11 (FRAC = 11).
- FRAC, 11: fractional bits of the input and output data.
- DEPTH, 4: output FIFO depth in entries; must be a power of 2, at least 2.
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  CORDIC output sample valid this cycle.
- x_in  input  WIDTH  CORDIC X output, which is the magnitude × K (Q4.11).
- theta_in  input  WIDTH  CORDIC accumulated angle in radians (Q4.11).
- quad_in  input  1  set if the original vector had X<0 and was pre-rotated by 180°. Delayed upstream to align with x_in.
- mag_out  output  WIDTH  gain-compensated magnitude (Q4.11).
- phase_out  output  WIDTH  corrected angle in (−π, π] (Q4.11).
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer accepts the head this cycle.
- overflow  output  1  sticky; a sample was dropped because the FIFO was full.

## Operation
- Constants:
  - KINV = 19898, which is 0.607253 in unsigned Q1.15.
  - PI_Q = 6434, which is π in Q4.11.
- Stage 1, registered when in_valid = 1:
  - Clamp: xc = (x_in < 0) ? 0 : x_in.
  - Product: prod = xc × KINV, a (WIDTH+16)-bit unsigned value.
  - theta_in, quad_in and valid are registered alongside prod.
- Stage 2, registered:
  - mag = prod >> 15, with rounding per Configuration.
  - The result always fits WIDTH−1 bits because KINV < 1, so no saturation is needed.
  - If quad = 0: phase = theta.
  - If quad = 1 and theta ≤ 0: phase = theta + PI_Q.
  - If quad = 1 and theta > 0: phase = theta − PI_Q.
  - The sum cannot overflow the Q4.11 range.
- FIFO write: when stage-2 valid = 1, {mag, phase} is written into the FIFO.
- FIFO read:
  - The FIFO is show-ahead: mag_out and phase_out come straight from the head entry.
  - out_valid = (count ≠ 0).
  - The head pops when out_valid && out_ready.
- Full FIFO:
  - A write while full with no pop in the same cycle is discarded, and overflow is set.
  - A write while full with a pop in the same cycle is accepted; count stays at DEPTH.
- Write and pop together at any other occupancy: count is unchanged.
- Empty FIFO: out_ready is ignored while out_valid = 0.
- overflow clears only on reset.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

## Timing
- Reset (rst = 0 at a clock edge) clears the following; there is no flush of FIFO memory contents:
  - pipeline valid bits, pointers, count and overflow;
  - mag_out and phase_out to 0;
  - out_valid to 0.
- Reset in the middle of operation discards in-flight and buffered samples at that edge.
- Latency: a sample presented at edge N is written at edge N+2. out_valid is high after edge N+2 if the FIFO was empty.
- Throughput: one sample per cycle, with no input backpressure.
- mag_out and phase_out are stable while out_valid = 1 and out_ready = 0.

## Configuration
- CORDIC_POST_ROUND_EN:
  - Defined: mag = (prod + 2^14) >> 15, round-half-up.
  - Undefined: mag = prod >> 15, truncation.
- Both variants keep identical latency and interface.

## Structure
- Shared package cordic_pkg holds:
  - KINV, PI_Q, the FRAC default;
  - the typedef for the {mag, phase} result word.
- One sub-module: cordic_post_fifo, a parameterized show-ahead FIFO with full/empty/count and drop-on-full.
- The arithmetic pipeline stays in the top level.

## Test plan
- Gain compensation: x_in = 25684, theta_in = 829, quad_in = 0, out_ready = 1.
  - Expected: mag_out = 15596, phase_out = 829, out_valid 2 cycles after input.
- Quadrant fix, positive theta: theta_in = 829, quad_in = 1 → phase_out = −5605.
- Quadrant fix, negative and zero theta:
  - theta_in = −829, quad_in = 1 → phase_out = 5605.
  - theta_in = 0, quad_in = 1 → phase_out = 6434.
- Rounding: x_in = 3.
  - With CORDIC_POST_ROUND_EN: mag_out = 2.
  - Without: mag_out = 1.
  - Negative input: x_in = −100 → mag_out = 0.
- Backpressure and overflow: out_ready = 0, then 6 back-to-back samples.
  - First 4 buffered, samples 5 and 6 dropped, overflow = 1.
  - Then raise out_ready: 4 pops in order, out_valid falls after the 4th pop.
  - A full FIFO with simultaneous pop and write accepts the write.
- Reset mid-stream: rst = 0 with 2 samples in flight and 3 buffered.
  - Next cycle: out_valid = 0, overflow = 0, mag_out = phase_out = 0.
  - No stale sample appears afterwards.
